multi_call_system: RTL and testbench
====================================

Name: multi_call_system

Overview:
Parametrised multi-channel successor to the single-seat attendant call light. Each of NUM_CH channels holds a call light that is set by call and cleared by cancel. A light left on for TIMEOUT_CYC cycles escalates to urgent. A service arbiter presents one channel to the attendant and clears it on acknowledge.

Parameters:
NUM_CH, 4, number of call channels (seats); range 2..16.
TIMEOUT_CYC, 16, cycles a light stays on before it escalates to urgent; must be >= 2.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
call  input  NUM_CH  per-channel call request, sampled each rising edge.
cancel  input  NUM_CH  per-channel cancel request, sampled each rising edge.
svc_ack  input  1  attendant acknowledge; clears channel svc_idx at the next edge.
light_state  output  NUM_CH  per-channel call light; registered.
urgent  output  NUM_CH  per-channel escalation flag; registered.
any_light  output  1  OR of light_state.
active_cnt  output  clog2(NUM_CH+1)  number of lit channels.
svc_valid  output  1  at least one channel lit.
svc_idx  output  clog2(NUM_CH)  channel currently offered for service.

Behaviour:
- Reset (rst_n=0, asynchronous): all channels go to IDLE, timers go to 0, and every output reads 0 immediately without waiting for a clock edge. Leaving reset is synchronous to clk.
- Per-channel FSM with states IDLE, ON and URGENT. light_state = (ON or URGENT); urgent = URGENT.
- A channel's clear condition is clr = cancel[i] OR (svc_ack AND svc_valid AND svc_idx==i).
- Call always has priority over a clear in the same cycle.
- IDLE: if call[i], go to ON and set timer to 0. Otherwise stay in IDLE; a cancel in IDLE has no effect.
- ON: if call[i], stay in ON. The timer keeps counting; re-calling does not restart it.
  - Else if clr, go to IDLE.
  - Else if timer == TIMEOUT_CYC-1, go to URGENT.
  - Else timer increments by 1.
  - Net effect: urgent rises exactly TIMEOUT_CYC clock edges after light_state rises.
- URGENT: if clr and not call[i], go to IDLE. Otherwise stay in URGENT; call is ignored.
- The timer saturates and does not wrap. Its width is clog2(TIMEOUT_CYC).
- Arbiter (combinational from the state registers, zero added latency):
  - If any channel is URGENT, svc_idx is the lowest-index URGENT channel.
  - Otherwise svc_idx is the lowest-index ON channel.
  - svc_valid = any_light. When svc_valid=0, svc_idx=0 and svc_ack is ignored.
- svc_ack clears only the channel that svc_idx shows at the sampling edge. One channel is cleared per ack cycle. Holding svc_ack high for k cycles clears k channels in arbiter order.
- active_cnt is the popcount of light_state and reaches NUM_CH when every channel is lit.
- Channels are independent. Simultaneous events on different channels are all applied in the same cycle.

Test Plan:
(All with NUM_CH=4, TIMEOUT_CYC=8.)
1. Release reset, then pulse call[1] for one cycle -> next edge: light_state=4'b0010, any_light=1, active_cnt=1, svc_valid=1, svc_idx=1, urgent=0. Cancel on idle ch0 -> light_state unchanged.
2. Assert call[2] and cancel[2] together from IDLE -> light_state[2]=1. Next cycle assert cancel[2] alone -> light_state[2]=0. Assert call[2] and cancel[2] together while lit -> light stays 1.
3. Light ch3 and hold it with no clear -> urgent[3]=1 exactly 8 edges after light_state[3] rose. Re-pulsing call[3] at cycle 4 does not delay the escalation.
4. Light ch0 after ch3 is URGENT -> svc_idx=3 (urgent wins over the lower index). Pulse svc_ack -> ch3 clears, svc_idx=0, active_cnt=1. Pulse svc_ack again -> svc_valid=0, svc_idx=0.
5. Light all 4 channels, then hold svc_ack for 2 cycles with no urgent channels -> ch0 then ch1 clear, leaving light_state=4'b1100 and active_cnt=2. svc_ack together with call on the served channel -> that light stays on.
6. All lit with ch2 URGENT, then drop rst_n mid-cycle -> all outputs 0 before the next clk edge. Release rst_n -> channels stay IDLE until called, and the timer restarts from 0 (urgent rises again only after 8 edges).

Source files
------------

// File: rtl/multi_call_system.sv
// Multi-channel attendant call-light controller.
// Each channel lights on call, clears on cancel or attendant acknowledge,
// and escalates to urgent after TIMEOUT_CYC edges left lit. A fixed-priority
// arbiter offers one channel for service: urgent channels first, then lowest index.
module multi_call_system #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CH-1:0]                call,
    input  logic [NUM_CH-1:0]                cancel,
    input  logic                             svc_ack,
    output logic [NUM_CH-1:0]                light_state,
    output logic [NUM_CH-1:0]                urgent,
    output logic                             any_light,
    output logic [$clog2(NUM_CH+1)-1:0]      active_cnt,
    output logic                             svc_valid,
    output logic [$clog2(NUM_CH)-1:0]        svc_idx
);

    localparam int unsigned IW = $clog2(NUM_CH);
    localparam int unsigned CW = $clog2(NUM_CH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

    // Two-bit encoding: bit 0 is the lit flag, bit 1 the urgent flag.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ON     = 2'b01,
        ST_URGENT = 2'b11
    } ch_state_e;

    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [TW-1:0]     timer_q [NUM_CH];
    logic [TW-1:0]     timer_d [NUM_CH];
    logic [NUM_CH-1:0] clr;

    // Per-channel state and timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // Light and urgent flags decoded straight from the state flops.
    always_comb begin
        light_state = '0;
        urgent      = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            light_state[i] = (state_q[i] != ST_IDLE);
            urgent[i]      = (state_q[i] == ST_URGENT);
        end
    end

    // Summary outputs: any lit channel and the lit-channel popcount.
    always_comb begin
        any_light  = |light_state;
        active_cnt = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            active_cnt = active_cnt + CW'(light_state[i]);
        end
    end

    // Service arbiter: lowest urgent channel, else lowest lit channel, else 0.
    always_comb begin
        logic          urg_found;
        logic          on_found;
        logic [IW-1:0] urg_idx;
        logic [IW-1:0] on_idx;
        urg_found = 1'b0;
        on_found  = 1'b0;
        urg_idx   = '0;
        on_idx    = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (urgent[i] && !urg_found) begin
                urg_found = 1'b1;
                urg_idx   = IW'(i);
            end
            if (light_state[i] && !on_found) begin
                on_found = 1'b1;
                on_idx   = IW'(i);
            end
        end
        svc_valid = any_light;
        if (urg_found) begin
            svc_idx = urg_idx;
        end else if (on_found) begin
            svc_idx = on_idx;
        end else begin
            svc_idx = '0;
        end
    end

    // Clear requests: cancel, or an acknowledge aimed at the offered channel.
    always_comb begin
        clr = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            clr[i] = cancel[i] | (svc_ack & svc_valid & (svc_idx == IW'(i)));
        end
    end

    // Per-channel next state; call beats clear, timer saturates at its last value.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (call[i]) begin
                        state_d[i] = ST_ON;
                        timer_d[i] = '0;
                    end
                end
                ST_ON: begin
                    if (call[i]) begin
                        if (timer_q[i] != TMR_LAST) begin
                            timer_d[i] = timer_q[i] + TW'(1);
                        end
                    end else if (clr[i]) begin
                        state_d[i] = ST_IDLE;
                        timer_d[i] = '0;
                    end else if (timer_q[i] == TMR_LAST) begin
                        state_d[i] = ST_URGENT;
                    end else begin
                        timer_d[i] = timer_q[i] + TW'(1);
                    end
                end
                ST_URGENT: begin
                    if (clr[i] && !call[i]) begin
                        state_d[i] = ST_IDLE;
                        timer_d[i] = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_call_system.sv
// Bench for multi_call_system: directed scenarios plus random traffic,
// all checked against a behavioural model of lights, ages and urgency.
module tb_multi_call_system;

    localparam int N = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] call;
    logic [3:0] cancel;
    logic       svc_ack;
    logic [3:0] light_state;
    logic [3:0] urgent;
    logic       any_light;
    logic [2:0] active_cnt;
    logic       svc_valid;
    logic [1:0] svc_idx;

    int checks   = 0;
    int failures = 0;

    // Model: lit flag, urgent flag and edges-since-lit (saturating) per seat.
    bit m_lit [N];
    bit m_urg [N];
    int m_age [N];

    multi_call_system #(.NUM_CH(N), .TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .call        (call),
        .cancel      (cancel),
        .svc_ack     (svc_ack),
        .light_state (light_state),
        .urgent      (urgent),
        .any_light   (any_light),
        .active_cnt  (active_cnt),
        .svc_valid   (svc_valid),
        .svc_idx     (svc_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_lit[i] = 1'b0;
            m_urg[i] = 1'b0;
            m_age[i] = 0;
        end
    endfunction

    function automatic logic [3:0] m_light_vec();
        logic [3:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_lit[i];
        return v;
    endfunction

    function automatic logic [3:0] m_urg_vec();
        logic [3:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_urg[i];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_lit[i]);
        return c;
    endfunction

    // Seat offered for service: first urgent seat, otherwise first lit seat.
    function automatic int m_offer();
        for (int i = 0; i < N; i++) if (m_urg[i]) return i;
        for (int i = 0; i < N; i++) if (m_lit[i]) return i;
        return 0;
    endfunction

    // Apply one clock edge of the call-light rules to the model.
    function automatic void m_edge(input logic [3:0] c, input logic [3:0] x, input logic a);
        int off;
        bit any;
        off = m_offer();
        any = (m_count() != 0);
        for (int i = 0; i < N; i++) begin
            bit clr;
            clr = x[i] || (a && any && off == i);
            if (!m_lit[i]) begin
                if (c[i]) begin
                    m_lit[i] = 1'b1;
                    m_age[i] = 0;
                end
            end else if (!m_urg[i]) begin
                if (c[i]) begin
                    if (m_age[i] < T - 1) m_age[i]++;
                end else if (clr) begin
                    m_lit[i] = 1'b0;
                end else if (m_age[i] == T - 1) begin
                    m_urg[i] = 1'b1;
                end else begin
                    m_age[i]++;
                end
            end else if (clr && !c[i]) begin
                m_lit[i] = 1'b0;
                m_urg[i] = 1'b0;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".light"},  32'(light_state), 32'(m_light_vec()));
        chk({tag, ".urgent"}, 32'(urgent),      32'(m_urg_vec()));
        chk({tag, ".any"},    32'(any_light),   32'(m_count() != 0));
        chk({tag, ".cnt"},    32'(active_cnt),  32'(m_count()));
        chk({tag, ".valid"},  32'(svc_valid),   32'(m_count() != 0));
        chk({tag, ".idx"},    32'(svc_idx),     32'(m_offer()));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check after it.
    task automatic step(input logic [3:0] c, input logic [3:0] x, input logic a, input string tag);
        call    = c;
        cancel  = x;
        svc_ack = a;
        @(posedge clk);
        m_edge(c, x, a);
        #1;
        check_all(tag);
        call    = '0;
        cancel  = '0;
        svc_ack = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        call    = '0;
        cancel  = '0;
        svc_ack = 1'b0;
        m_reset();
        #3;
        check_all("reset");
        chk("reset.light0", 32'(light_state), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single call lights seat 1; cancel on an idle seat does nothing
        step(4'b0010, 4'b0000, 1'b0, "t1_call");
        chk("t1.light", 32'(light_state), 32'h2);
        chk("t1.idx",   32'(svc_idx),     32'd1);
        step(4'b0000, 4'b0001, 1'b0, "t1_cancel_idle");
        chk("t1.light_keep", 32'(light_state), 32'h2);

        // 2: call beats cancel both from idle and while lit
        do_reset("t2_reset");
        step(4'b0100, 4'b0100, 1'b0, "t2_both_idle");
        chk("t2.lit", 32'(light_state[2]), 32'd1);
        step(4'b0000, 4'b0100, 1'b0, "t2_cancel");
        chk("t2.off", 32'(light_state[2]), 32'd0);
        step(4'b0100, 4'b0000, 1'b0, "t2_relight");
        step(4'b0100, 4'b0100, 1'b0, "t2_both_lit");
        chk("t2.stay", 32'(light_state[2]), 32'd1);

        // 3: escalation exactly T edges after lighting, re-call does not delay it
        do_reset("t3_reset");
        step(4'b1000, 4'b0000, 1'b0, "t3_light");
        for (int k = 1; k <= T; k++) begin
            step((k == 4) ? 4'b1000 : 4'b0000, 4'b0000, 1'b0, "t3_wait");
            if (k == T - 1) chk("t3.not_yet", 32'(urgent[3]), 32'd0);
            if (k == T)     chk("t3.urgent",  32'(urgent[3]), 32'd1);
        end

        // 4: urgent seat outranks a lower index; acks clear in arbiter order
        step(4'b0001, 4'b0000, 1'b0, "t4_light0");
        chk("t4.idx_urg", 32'(svc_idx), 32'd3);
        step(4'b0000, 4'b0000, 1'b1, "t4_ack1");
        chk("t4.idx0", 32'(svc_idx),    32'd0);
        chk("t4.cnt1", 32'(active_cnt), 32'd1);
        step(4'b0000, 4'b0000, 1'b1, "t4_ack2");
        chk("t4.valid0", 32'(svc_valid), 32'd0);

        // 5: held ack clears one seat per cycle; call protects the served seat
        do_reset("t5_reset");
        step(4'b1111, 4'b0000, 1'b0, "t5_all");
        chk("t5.cnt4", 32'(active_cnt), 32'd4);
        step(4'b0000, 4'b0000, 1'b1, "t5_ack1");
        step(4'b0000, 4'b0000, 1'b1, "t5_ack2");
        chk("t5.light", 32'(light_state), 32'hC);
        chk("t5.cnt2",  32'(active_cnt),  32'd2);
        step(4'b0100, 4'b0000, 1'b1, "t5_ack_call");
        chk("t5.keep", 32'(light_state), 32'hC);

        // 6: asynchronous reset mid-cycle, then timer restarts from zero
        do_reset("t6_reset");
        step(4'b0100, 4'b0000, 1'b0, "t6_light2");
        for (int k = 1; k <= T; k++) step(4'b0000, 4'b0000, 1'b0, "t6_wait");
        step(4'b1011, 4'b0000, 1'b0, "t6_all");
        chk("t6.urg2", 32'(urgent), 32'h4);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all("t6_async");
        chk("t6.async_light", 32'(light_state), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, "t6_idle");
        step(4'b0100, 4'b0000, 1'b0, "t6_relight");
        for (int k = 1; k <= T; k++) begin
            step(4'b0000, 4'b0000, 1'b0, "t6_rewait");
            if (k == T - 1) chk("t6.not_yet", 32'(urgent[2]), 32'd0);
            if (k == T)     chk("t6.urgent",  32'(urgent[2]), 32'd1);
        end

        // Random traffic against the model, with occasional resets
        do_reset("rnd_reset");
        for (int n = 0; n < 800; n++) begin
            logic [3:0] c;
            logic [3:0] x;
            logic       a;
            for (int b = 0; b < N; b++) begin
                c[b] = ($urandom_range(0, 5) == 0);
                x[b] = ($urandom_range(0, 9) == 0);
            end
            a = ($urandom_range(0, 3) == 0);
            step(c, x, a, "rnd");
            if (n % 200 == 199) do_reset("rnd_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
